// File: rtl/mem_stage_lsu_if.sv
// rtl/mem_stage_lsu_if.sv - request/grant/response data-memory bus between the LSU and data memory
interface mem_stage_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit: bus sequencing, lane steering, load formatting, stall
// Optional misaligned-access trap (adds misalign_m) enabled by defining LSU_MISALIGN_TRAP_EN.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read_m,
  input  logic        mem_write_m,
  input  logic [2:0]  funct3_m,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] write_data_m,
  output logic [31:0] read_data_m,
  output logic        stall_m,
  output logic        bus_err_m,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic        misalign_m,
`endif
  mem_stage_lsu_if.master dmem
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state_q, state_d;

  logic [31:0]      addr_q;
  logic [2:0]       f3_q;
  logic             we_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic [1:0]  size_m;
  logic [1:0]  off_m;
  logic [3:0]  be_m;
  logic [31:0] wdata_m;
  logic        access_m;
  logic        timeout_hit;

  logic cap_en, cnt_clr, cnt_inc, rd_load, rd_clear, err_set, mis_set;

  // 0 = byte, 1 = half, 2 = word; reserved encodings fall through to word
  function automatic logic [1:0] size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: size_of = 2'd0;
      3'b001, 3'b101: size_of = 2'd1;
      default:        size_of = 2'd2;
    endcase
  endfunction

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (size_of(f3))
      2'd0:    fmt_load = f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
      2'd1:    fmt_load = f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: fmt_load = w;
    endcase
  endfunction

  assign access_m    = mem_read_m | mem_write_m;
  assign size_m      = size_of(funct3_m);
  assign off_m       = alu_result_m[1:0];
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    be_m    = 4'b1111;
    wdata_m = write_data_m;
    case (size_m)
      2'd0: begin
        be_m    = 4'b0001 << off_m;
        wdata_m = {4{write_data_m[7:0]}};
      end
      2'd1: begin
        be_m    = 4'b0011 << {off_m[1], 1'b0};
        wdata_m = {2{write_data_m[15:0]}};
      end
      default: begin
        be_m    = 4'b1111;
        wdata_m = write_data_m;
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned_m;
  logic mis_q;
  assign misaligned_m = ((size_m == 2'd1) && off_m[0]) || ((size_m == 2'd2) && (off_m != 2'b00));
  assign misalign_m   = mis_q;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    stall_m  = 1'b0;
    cap_en   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    rd_load  = 1'b0;
    rd_clear = 1'b0;
    err_set  = 1'b0;
    mis_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (access_m) begin
          stall_m = 1'b1;
          cap_en  = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
          if (misaligned_m) begin
            state_d  = DONE;
            mis_set  = 1'b1;
            rd_clear = 1'b1;
          end else begin
            state_d = REQ;
            cnt_clr = 1'b1;
          end
`else
          state_d = REQ;
          cnt_clr = 1'b1;
`endif
        end
      end
      REQ: begin
        stall_m = 1'b1;
        cnt_inc = 1'b1;
        if (dmem.dmem_gnt) begin
          if (we_q) begin
            state_d = DONE;
          end else if (dmem.dmem_rvalid) begin
            rd_load = 1'b1;
            state_d = DONE;
          end else begin
            state_d = WAIT;
            cnt_clr = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d  = DONE;
          err_set  = 1'b1;
          rd_clear = 1'b1;
        end
      end
      WAIT: begin
        stall_m = 1'b1;
        cnt_inc = 1'b1;
        if (dmem.dmem_rvalid) begin
          rd_load = 1'b1;
          state_d = DONE;
        end else if (timeout_hit) begin
          state_d  = DONE;
          err_set  = 1'b1;
          rd_clear = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q  <= 32'b0;
      f3_q    <= 3'b0;
      we_q    <= 1'b0;
      be_q    <= 4'b0;
      wdata_q <= 32'b0;
    end else if (cap_en) begin
      addr_q  <= alu_result_m;
      f3_q    <= funct3_m;
      we_q    <= mem_write_m;
      be_q    <= be_m;
      wdata_q <= wdata_m;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        cnt_q <= '0;
    else if (cnt_clr) cnt_q <= '0;
    else if (cnt_inc) cnt_q <= cnt_q + 1'b1;
  end

  // Load result persists across stores so MEM/WB sees the last load until the next one lands
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read_data_m <= 32'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= err_set;
      if (rd_load)       read_data_m <= fmt_load(dmem.dmem_rdata, f3_q, addr_q[1:0]);
      else if (rd_clear) read_data_m <= 32'b0;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) mis_q <= 1'b0;
    else       mis_q <= mis_set;
  end
`endif

  assign bus_err_m       = err_q;
  assign dmem.dmem_req   = (state_q == REQ);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;
  logic        clock = 1'b0;
  logic        reset;
  logic        mem_read_m, mem_write_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m, write_data_m;
  logic [31:0] read_data_m;
  logic        stall_m, bus_err_m;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_m;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  mem_stage_lsu_if dmem_bus ();

  mem_stage_lsu #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .mem_read_m   (mem_read_m),
    .mem_write_m  (mem_write_m),
    .funct3_m     (funct3_m),
    .alu_result_m (alu_result_m),
    .write_data_m (write_data_m),
    .read_data_m  (read_data_m),
    .stall_m      (stall_m),
    .bus_err_m    (bus_err_m),
`ifdef LSU_MISALIGN_TRAP_EN
    .misalign_m   (misalign_m),
`endif
    .dmem         (dmem_bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives one MEM-stage access to completion and reports what was observed on the way.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int gnt_at, input int rv_at, input logic [31:0] resp,
                            output int stall_cycles, output int req_cycles,
                            output logic done_seen, output logic [31:0] rd_out,
                            output logic err_out, output logic mis_out,
                            output logic [3:0] be_seen, output logic [31:0] addr_seen,
                            output logic [31:0] wdata_seen, output logic we_seen);
    int gcyc;
    stall_cycles = 0; req_cycles = 0; done_seen = 1'b0; rd_out = '0; err_out = 1'b0;
    mis_out = 1'b0; be_seen = '0; addr_seen = '0; wdata_seen = '0; we_seen = 1'b0;
    gcyc = -1;
    mem_read_m = rd; mem_write_m = wr; funct3_m = f3; alu_result_m = addr; write_data_m = wd;
    for (int k = 0; k < 40 && !done_seen; k++) begin
      dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = 32'h0;
      if (dmem_bus.dmem_req) begin
        if (req_cycles == 0) begin
          be_seen = dmem_bus.dmem_be; addr_seen = dmem_bus.dmem_addr;
          wdata_seen = dmem_bus.dmem_wdata; we_seen = dmem_bus.dmem_we;
        end
        if (req_cycles == gnt_at) begin
          dmem_bus.dmem_gnt = 1'b1;
          gcyc = k;
        end
        req_cycles++;
      end
      if (rd && gcyc >= 0 && k == gcyc + rv_at) begin
        dmem_bus.dmem_rvalid = 1'b1;
        dmem_bus.dmem_rdata  = resp;
      end
      #1;
      if (k > 0 && !stall_m) begin
        done_seen = 1'b1;
        rd_out = read_data_m;
        err_out = bus_err_m;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_out = misalign_m;
`endif
        mem_read_m = 1'b0; mem_write_m = 1'b0;
      end else begin
        stall_cycles++;
      end
      @(posedge clock);
      #1;
    end
    mem_read_m = 1'b0; mem_write_m = 1'b0;
    dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = 32'h0;
  endtask

  task automatic test_reset();
    tests_run++; if (read_data_m !== 32'h0) begin tests_failed++; $display("FAIL reset_read_data: got %h expected %h", read_data_m, 32'h0); end
    tests_run++; if (stall_m !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b expected 0", stall_m); end
    tests_run++; if (bus_err_m !== 1'b0) begin tests_failed++; $display("FAIL reset_bus_err: got %b expected 0", bus_err_m); end
    tests_run++; if (dmem_bus.dmem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b expected 0", dmem_bus.dmem_req); end
    tests_run++; if ({dmem_bus.dmem_we, dmem_bus.dmem_be, dmem_bus.dmem_addr, dmem_bus.dmem_wdata} !== 69'h0) begin
      tests_failed++; $display("FAIL reset_bus: got we=%b be=%b addr=%h wdata=%h expected all 0",
                               dmem_bus.dmem_we, dmem_bus.dmem_be, dmem_bus.dmem_addr, dmem_bus.dmem_wdata);
    end
  endtask

  task automatic test_lw();
    int sc, rc; logic dn, er, mi, we; logic [31:0] rd, ad, wdv; logic [3:0] be;
    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 2, 32'hCAFEBABE, sc, rc, dn, rd, er, mi, be, ad, wdv, we);
    tests_run++; if (dn !== 1'b1) begin tests_failed++; $display("FAIL lw_done: got %b expected 1", dn); end
    tests_run++; if (be !== 4'b1111) begin tests_failed++; $display("FAIL lw_be: got %b expected 1111", be); end
    tests_run++; if (ad !== 32'h100) begin tests_failed++; $display("FAIL lw_addr: got %h expected 00000100", ad); end
    tests_run++; if (sc !== 4) begin tests_failed++; $display("FAIL lw_stall_cycles: got %0d expected 4", sc); end
    tests_run++; if (rd !== 32'hCAFEBABE) begin tests_failed++; $display("FAIL lw_data: got %h expected cafebabe", rd); end
    tests_run++; if (er !== 1'b0) begin tests_failed++; $display("FAIL lw_err: got %b expected 0", er); end
  endtask

  task automatic test_sb();
    int sc, rc; logic dn, er, mi, we; logic [31:0] rd, ad, wdv; logic [3:0] be;
    run_access(1'b0, 1'b1, 3'b000, 32'h203, 32'h000000A5, 2, 0, 32'h0, sc, rc, dn, rd, er, mi, be, ad, wdv, we);
    tests_run++; if (ad !== 32'h200) begin tests_failed++; $display("FAIL sb_addr: got %h expected 00000200", ad); end
    tests_run++; if (be !== 4'b1000) begin tests_failed++; $display("FAIL sb_be: got %b expected 1000", be); end
    tests_run++; if (wdv !== 32'hA5A5A5A5) begin tests_failed++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", wdv); end
    tests_run++; if (we !== 1'b1) begin tests_failed++; $display("FAIL sb_we: got %b expected 1", we); end
    tests_run++; if (rc !== 3) begin tests_failed++; $display("FAIL sb_req_cycles: got %0d expected 3", rc); end
    tests_run++; if (sc !== 4) begin tests_failed++; $display("FAIL sb_stall_cycles: got %0d expected 4", sc); end
    tests_run++; if (rd !== 32'hCAFEBABE) begin tests_failed++; $display("FAIL sb_read_data_hold: got %h expected cafebabe", rd); end
  endtask

  task automatic test_load_format();
    int sc, rc; logic dn, er, mi, we; logic [31:0] rd, ad, wdv; logic [3:0] be;
    run_access(1'b1, 1'b0, 3'b000, 32'h302, 32'h0, 0, 0, 32'h1280FF00, sc, rc, dn, rd, er, mi, be, ad, wdv, we);
    tests_run++; if (rd !== 32'hFFFFFF80) begin tests_failed++; $display("FAIL lb_data: got %h expected ffffff80", rd); end
    tests_run++; if (be !== 4'b0100) begin tests_failed++; $display("FAIL lb_be: got %b expected 0100", be); end
    tests_run++; if (sc !== 2) begin tests_failed++; $display("FAIL lb_same_cycle_stall: got %0d expected 2", sc); end
    run_access(1'b1, 1'b0, 3'b100, 32'h302, 32'h0, 0, 1, 32'h1280FF00, sc, rc, dn, rd, er, mi, be, ad, wdv, we);
    tests_run++; if (rd !== 32'h00000080) begin tests_failed++; $display("FAIL lbu_data: got %h expected 00000080", rd); end
    run_access(1'b1, 1'b0, 3'b101, 32'h300, 32'h0, 1, 1, 32'h1280FF00, sc, rc, dn, rd, er, mi, be, ad, wdv, we);
    tests_run++; if (rd !== 32'h0000FF00) begin tests_failed++; $display("FAIL lhu_data: got %h expected 0000ff00", rd); end
    run_access(1'b1, 1'b0, 3'b001, 32'h300, 32'h0, 0, 1, 32'h1280FF00, sc, rc, dn, rd, er, mi, be, ad, wdv, we);
    tests_run++; if (rd !== 32'hFFFFFF00) begin tests_failed++; $display("FAIL lh_lo_data: got %h expected ffffff00", rd); end
    run_access(1'b1, 1'b0, 3'b001, 32'h302, 32'h0, 0, 1, 32'h1280FF00, sc, rc, dn, rd, er, mi, be, ad, wdv, we);
    tests_run++; if (rd !== 32'h00001280) begin tests_failed++; $display("FAIL lh_data: got %h expected 00001280", rd); end
    tests_run++; if (be !== 4'b1100) begin tests_failed++; $display("FAIL lh_be: got %b expected 1100", be); end
  endtask

  task automatic test_timeout();
    int sc, rc; logic dn, er, mi, we; logic [31:0] rd, ad, wdv; logic [3:0] be;
    run_access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, -1, 0, 32'h0, sc, rc, dn, rd, er, mi, be, ad, wdv, we);
    tests_run++; if (dn !== 1'b1) begin tests_failed++; $display("FAIL to_done: got %b expected 1", dn); end
    tests_run++; if (rc !== 4) begin tests_failed++; $display("FAIL to_req_cycles: got %0d expected 4", rc); end
    tests_run++; if (er !== 1'b1) begin tests_failed++; $display("FAIL to_bus_err: got %b expected 1", er); end
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL to_data: got %h expected 00000000", rd); end
    tests_run++; if (bus_err_m !== 1'b0) begin tests_failed++; $display("FAIL to_err_pulse: got %b expected 0", bus_err_m); end
  endtask

  task automatic test_misalign();
    int sc, rc; logic dn, er, mi, we; logic [31:0] rd, ad, wdv; logic [3:0] be;
`ifdef LSU_MISALIGN_TRAP_EN
    run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 1, 32'h11223344, sc, rc, dn, rd, er, mi, be, ad, wdv, we);
    tests_run++; if (rc !== 0) begin tests_failed++; $display("FAIL mis_req_cycles: got %0d expected 0", rc); end
    tests_run++; if (sc !== 1) begin tests_failed++; $display("FAIL mis_stall_cycles: got %0d expected 1", sc); end
    tests_run++; if (mi !== 1'b1) begin tests_failed++; $display("FAIL mis_flag: got %b expected 1", mi); end
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL mis_data: got %h expected 00000000", rd); end
    tests_run++; if (misalign_m !== 1'b0) begin tests_failed++; $display("FAIL mis_pulse: got %b expected 0", misalign_m); end
`else
    run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 1, 32'h11223344, sc, rc, dn, rd, er, mi, be, ad, wdv, we);
    tests_run++; if (be !== 4'b1111) begin tests_failed++; $display("FAIL unaligned_be: got %b expected 1111", be); end
    tests_run++; if (ad !== 32'h100) begin tests_failed++; $display("FAIL unaligned_addr: got %h expected 00000100", ad); end
    tests_run++; if (rd !== 32'h11223344) begin tests_failed++; $display("FAIL unaligned_data: got %h expected 11223344", rd); end
`endif
  endtask

  task automatic test_reset_mid();
    mem_read_m = 1'b1; funct3_m = 3'b010; alu_result_m = 32'h500;
    tick();
    dmem_bus.dmem_gnt = 1'b1;
    tick();
    dmem_bus.dmem_gnt = 1'b0;
    tick();
    reset = 1'b1; mem_read_m = 1'b0;
    #1;
    tests_run++; if (dmem_bus.dmem_req !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_req: got %b expected 0", dmem_bus.dmem_req); end
    tests_run++; if (stall_m !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_stall: got %b expected 0", stall_m); end
    tick();
    reset = 1'b0;
    dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = 32'hDEADBEEF;
    tick();
    dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = 32'h0;
    tick();
    tests_run++; if (read_data_m !== 32'h0) begin tests_failed++; $display("FAIL rst_mid_data: got %h expected 00000000", read_data_m); end
    tests_run++; if (stall_m !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_idle_stall: got %b expected 0", stall_m); end
    tests_run++; if (dmem_bus.dmem_req !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_idle_req: got %b expected 0", dmem_bus.dmem_req); end
  endtask

  initial begin
    reset = 1'b1;
    mem_read_m = 1'b0; mem_write_m = 1'b0; funct3_m = 3'b0;
    alu_result_m = 32'h0; write_data_m = 32'h0;
    dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = 32'h0;
    tick();
    tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_lw();
    test_sb();
    test_load_format();
    test_timeout();
    test_misalign();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit; sits directly upstream of the MEM/WB pipeline register.
- Drives a request/grant/response data-memory bus from MEM-stage control.
- Formats load data (byte/half/word, sign/zero extend) and presents it as read_data_m to MEM/WB.
- Stalls the pipeline via stall_m while a bus transaction is outstanding; the hazard unit deasserts MEM/WB enable on stall_m.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in REQ or WAIT before an access is aborted with bus_err_m.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- mem_read_m  in  1  MEM-stage instruction is a load
- mem_write_m  in  1  MEM-stage instruction is a store (never both with mem_read_m)
- funct3_m  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- alu_result_m  in  32  effective byte address
- write_data_m  in  32  store data (rs2), LSB-aligned
- read_data_m  out  32  formatted load data, valid in DONE
- stall_m  out  1  freeze IF..MEM and hold MEM/WB
- bus_err_m  out  1  one-cycle pulse in DONE when the access timed out
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address: {addr[31:2], 2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid this cycle
- dmem_rdata  in  32  read data word

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. Reset -> IDLE.
- Reset values: all outputs 0; captured address, size, and data registers 0; timeout counter 0.
- IDLE:
  - If mem_read_m or mem_write_m is high, capture addr, funct3, we, be, and wdata; go to REQ; stall_m=1 combinationally this cycle.
  - Otherwise stall_m=0.
- REQ:
  - dmem_req=1; bus outputs driven from captured registers and held stable until gnt; stall_m=1.
  - On gnt: store -> DONE; load -> WAIT.
  - gnt and rvalid in the same cycle for a load: capture rdata, go to DONE.
- WAIT:
  - dmem_req=0; stall_m=1.
  - On rvalid: register the formatted data into read_data_m; go to DONE.
- DONE:
  - stall_m=0 for exactly one cycle; the pipeline advances and MEM/WB samples read_data_m.
  - Next state is always IDLE. The same instruction is never re-issued because IDLE samples the new occupant.
- Timeout:
  - Counter clears on entry to REQ and on entry to WAIT; increments each cycle spent in REQ or WAIT.
  - When the counter reaches TIMEOUT_CYCLES, go to DONE with bus_err_m=1 and read_data_m=0.
- Byte enables (off = alu_result_m[1:0]):
  - Byte: 4'b0001 << off.
  - Half: 4'b0011 << {off[1],1'b0}.
  - Word: 4'b1111.
- Store data replication:
  - Byte: {4{wd[7:0]}}.
  - Half: {2{wd[15:0]}}.
  - Word: wd.
- Load format: select byte rdata[8*off +: 8] or half rdata[16*off[1] +: 16]; sign-extend for LB/LH, zero-extend for LBU/LHU; word passes through.
- read_data_m holds its value until the next load completes; it is not cleared by stores.
- Stray rvalid in IDLE, REQ, or DONE is ignored.
- Reset mid-transaction: immediately IDLE with dmem_req=0. A response still in flight is discarded.
- Undefined funct3 (011, 110, 111) is treated as word.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - IDLE checks alignment: half needs addr[0]=0; word needs addr[1:0]=0.
  - On a misaligned access: no bus request; go straight to DONE (one stall cycle) with misalign_m=1 for that cycle and read_data_m=0.
  - misalign_m is an extra 1-bit output port, reset 0.
- Undefined: no alignment check and no misalign_m port. The low offset bits select lanes as above, with the shift truncated to 4 bits.

Test Plan:
- LW at 0x100, gnt the same cycle, rvalid 2 cycles later with 0xCAFEBABE -> dmem_be=1111; stall_m high for 4 cycles; read_data_m=0xCAFEBABE in DONE.
- SB at 0x203, write_data_m=0x000000A5, gnt after 3 cycles -> dmem_addr=0x200, be=1000, wdata=0xA5A5A5A5; dmem_req held 3 cycles; no WAIT state.
- LB vs. LBU at 0x302 with rdata 0x1280FF00 -> 0xFFFFFF80 and 0x00000080 respectively; LH at 0x302 -> 0x00001280.
- Load with gnt never asserted, TIMEOUT_CYCLES=4 -> DONE after 4 REQ cycles; bus_err_m pulses; read_data_m=0.
- Reset asserted in WAIT, then rvalid arrives -> dmem_req=0, state IDLE, stall_m=0; rvalid ignored and read_data_m stays 0.
- With LSU_MISALIGN_TRAP_EN: LW at 0x101 -> no dmem_req; one stall cycle; misalign_m=1. Without the macro, the same access has be=1111 and dmem_addr=0x100.
